// File: rtl/jedro_1_mem_arbiter.sv
// jedro_1_mem_arbiter: shares one 1-cycle-latency RAM between fetch and load/store.
// JEDRO_1_ARB_RR_EN selects strict round-robin instead of LSU priority with a streak limit.
module jedro_1_mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    ifu_req_i,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_gnt_o,
  output logic                    ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    ram_en_o,
  output logic [DATA_WIDTH/8-1:0] ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
  typedef enum logic [1:0] {OWN_IDLE, OWN_IFU, OWN_LSU} owner_e;
  owner_e owner_q, owner_d;
  logic   ifu_win, lsu_win;
`ifdef JEDRO_1_ARB_RR_EN
  // Starts at 1 so the LSU wins the first contended cycle after reset.
  logic last_ifu_q, last_ifu_d;
  always_comb begin
    lsu_win    = lsu_req_i && (!ifu_req_i || last_ifu_q);
    ifu_win    = ifu_req_i && !lsu_win;
    last_ifu_d = lsu_win ? 1'b0 : ifu_win ? 1'b1 : last_ifu_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_ifu_q <= 1'b1;
    else         last_ifu_q <= last_ifu_d;
  end
`else
  logic [3:0] streak_q, streak_d;
  logic       under_lim;
  always_comb begin
    under_lim = streak_q < 4'(MAX_LSU_STREAK);
    lsu_win   = lsu_req_i && (under_lim || !ifu_req_i);
    ifu_win   = ifu_req_i && !lsu_win;
    streak_d  = (!ifu_req_i || ifu_win) ? 4'd0 :
                (lsu_win && under_lim)  ? streak_q + 4'd1 : streak_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) streak_q <= 4'd0;
    else         streak_q <= streak_d;
  end
`endif
  always_comb begin
    ifu_gnt_o    = ifu_win;
    lsu_gnt_o    = lsu_win;
    ram_en_o     = ifu_win || lsu_win;
    ram_addr_o   = lsu_win ? lsu_addr_i : ifu_win ? ifu_addr_i : '0;
    ram_wdata_o  = lsu_win ? lsu_wdata_i : '0;
    ram_we_o     = (lsu_win && lsu_we_i) ? lsu_be_i : '0;
    owner_d      = lsu_win ? OWN_LSU : ifu_win ? OWN_IFU : OWN_IDLE;
    ifu_rvalid_o = owner_q == OWN_IFU;
    lsu_rvalid_o = owner_q == OWN_LSU;
    ifu_rdata_o  = ifu_rvalid_o ? ram_rdata_i : '0;
    lsu_rdata_o  = lsu_rvalid_o ? ram_rdata_i : '0;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) owner_q <= OWN_IDLE;
    else         owner_q <= owner_d;
  end
endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// tb_jedro_1_mem_arbiter: directed checks of grants, RAM drive and response routing.
module tb_jedro_1_mem_arbiter;
  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        ifu_req_i = 1'b0, lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [31:0] ifu_addr_i = '0, lsu_addr_i = '0, lsu_wdata_i = '0;
  logic [3:0]  lsu_be_i = '0;
  logic        ifu_gnt_o, ifu_rvalid_o, lsu_gnt_o, lsu_rvalid_o, ram_en_o;
  logic [31:0] ifu_rdata_o, lsu_rdata_o, ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;
  logic [3:0]  ram_we_o;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  typedef struct packed {logic [1:0] who; logic chk; logic [31:0] data;} resp_t;
  resp_t sbq[$];
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  jedro_1_mem_arbiter dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Behavioural single-port RAM, read-first, 1-cycle latency.
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // exp_win: 0 none, 1 IFU, 2 LSU
  task automatic tick(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                      input logic [3:0] lb, input logic [31:0] la, input logic [31:0] ld,
                      input logic [1:0] exp_win);
    resp_t r;
    logic [31:0] w;
    @(negedge clk);
    ifu_req_i = ir; ifu_addr_i = ia; lsu_req_i = lr; lsu_we_i = lw;
    lsu_be_i = lb; lsu_addr_i = la; lsu_wdata_i = ld;
    #1;
    r = (sbq.size() > 0) ? sbq.pop_front() : '0;
    chk("ifu_rvalid", 32'(ifu_rvalid_o), 32'(r.who == 2'd1));
    chk("lsu_rvalid", 32'(lsu_rvalid_o), 32'(r.who == 2'd2));
    if (r.who != 2'd1) chk("ifu_rdata_idle", ifu_rdata_o, 32'h0);
    if (r.chk && r.who == 2'd1) chk("ifu_rdata", ifu_rdata_o, r.data);
    if (r.chk && r.who == 2'd2) chk("lsu_rdata", lsu_rdata_o, r.data);
    chk("gnt", {30'd0, ifu_gnt_o, lsu_gnt_o}, {30'd0, exp_win == 2'd1, exp_win == 2'd2});
    chk("ram_en", 32'(ram_en_o), 32'(exp_win != 2'd0));
    chk("ram_addr", ram_addr_o, exp_win == 2'd2 ? la : exp_win == 2'd1 ? ia : 32'h0);
    chk("ram_we", 32'(ram_we_o), 32'((exp_win == 2'd2 && lw) ? lb : 4'h0));
    if (exp_win == 2'd1) sbq.push_back('{2'd1, 1'b1, ref_mem[ia[9:2]]});
    if (exp_win == 2'd2 && lw) begin
      w = ref_mem[la[9:2]];
      for (int b = 0; b < 4; b++) if (lb[b]) w[8*b +: 8] = ld[8*b +: 8];
      ref_mem[la[9:2]] = w;
      sbq.push_back('{2'd2, 1'b0, 32'h0});
    end
    if (exp_win == 2'd2 && !lw) sbq.push_back('{2'd2, 1'b1, ref_mem[la[9:2]]});
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd0);
  endtask

  initial begin
    logic [1:0] pat [10];
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[0] <= 32'h00100093; ref_mem[0] = 32'h00100093;
    mem[1] <= 32'h00200113; ref_mem[1] = 32'h00200113;
    mem[2] <= 32'h00300193; ref_mem[2] = 32'h00300193;
    #2;
    chk("rst_ifu_rvalid", 32'(ifu_rvalid_o), 32'h0);
    chk("rst_lsu_rvalid", 32'(lsu_rvalid_o), 32'h0);
    chk("rst_ram_en", 32'(ram_en_o), 32'h0);
    @(negedge clk); @(negedge clk);
    rstn_i = 1'b1;
    // fetch-only burst
    tick(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1);
    tick(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1);
    tick(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1);
    idle();
    idle();
    // write, then read back
    tick(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 32'h55C, 2'd2);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 2'd2);
    idle();
    // partial byte-enable write
    tick(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h104, 32'hFFFFFFFF, 2'd2);
    tick(1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h104, 32'hAABBCCDD, 2'd2);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0, 2'd2);
    idle();
    chk("be_merge", ref_mem[65], 32'hFFFFCCDD);
    // reset one cycle after an IFU grant
    tick(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1);
    @(negedge clk);
    ifu_req_i = 1'b0; lsu_req_i = 1'b0; rstn_i = 1'b0;
    #1;
    chk("rst_mid_ifu_rvalid", 32'(ifu_rvalid_o), 32'h0);
    chk("rst_mid_lsu_rvalid", 32'(lsu_rvalid_o), 32'h0);
    sbq.delete();
    @(negedge clk);
    rstn_i = 1'b1;
    idle();
    // continuous contention, starting from the post-reset state
`ifdef JEDRO_1_ARB_RR_EN
    pat = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
`else
    pat = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
`endif
    for (int i = 0; i < 10; i++)
      tick(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h108, 32'h0, pat[i]);
    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/jedro_1_mem_arbiter.md
# jedro_1_mem_arbiter

Two-requester arbiter sharing one single-port synchronous RAM between the jedro_1 instruction fetch path and the load/store path. It sits between `jedro_1_top`'s fetch/LSU request ports and a single RAM macro with 1-cycle read latency. The LSU has priority, bounded by a starvation counter, so a test program still makes forward progress during store/load bursts. It tracks the owner of the in-flight access and routes the response back to the correct requester.

## Interface
- `DATA_WIDTH`, 32, data bus width; must be a multiple of 8.
- `ADDR_WIDTH`, 32, byte address width.
- `MAX_LSU_STREAK`, 4, max consecutive LSU grants while IFU is waiting; range 1..15.

Ports:
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  async active-low reset.
- `ifu_req_i`  in  1  fetch request.
- `ifu_addr_i`  in  ADDR_WIDTH  fetch byte address.
- `ifu_gnt_o`  out  1  fetch request accepted this cycle.
- `ifu_rvalid_o`  out  1  fetch data valid.
- `ifu_rdata_o`  out  DATA_WIDTH  fetch data.
- `lsu_req_i`  in  1  data request.
- `lsu_we_i`  in  1  1 = write.
- `lsu_be_i`  in  DATA_WIDTH/8  byte enables.
- `lsu_addr_i`  in  ADDR_WIDTH  data byte address.
- `lsu_wdata_i`  in  DATA_WIDTH  write data.
- `lsu_gnt_o`  out  1  data request accepted.
- `lsu_rvalid_o`  out  1  read data valid / write acknowledge.
- `lsu_rdata_o`  out  DATA_WIDTH  read data.
- `ram_en_o`  out  1  RAM access this cycle.
- `ram_we_o`  out  DATA_WIDTH/8  per-byte write strobe.
- `ram_addr_o`  out  ADDR_WIDTH  RAM byte address.
- `ram_wdata_o`  out  DATA_WIDTH  RAM write data.
- `ram_rdata_i`  in  DATA_WIDTH  RAM read data, valid 1 cycle after `ram_en_o`.

## Operation
- **Grant decision.** Combinational, one grant per cycle. `ifu_gnt_o` and `lsu_gnt_o` are never both 1.
  - LSU wins when `lsu_req_i` is high and `streak_q < MAX_LSU_STREAK`.
  - Otherwise the IFU wins if `ifu_req_i` is high.
  - Otherwise the LSU wins if `lsu_req_i` is high.
- **Streak counter.** Registered, 4-bit.
  - Increments on an LSU grant while `ifu_req_i` is high.
  - Clears on any IFU grant, or on a cycle where `ifu_req_i` is low.
  - Saturates at `MAX_LSU_STREAK`.
- **RAM drive.**
  - `ram_en_o` = any grant.
  - `ram_addr_o` and `ram_wdata_o` are taken from the winner.
  - `ram_we_o` = `lsu_be_i` when the LSU wins with `lsu_we_i`=1; otherwise 0.
  - With no grant, `ram_addr_o`, `ram_wdata_o` and `ram_we_o` are 0.
- **Owner register.** Registered `owner_q`, with values IDLE, IFU and LSU; set from the grant each cycle.
- **Response routing.**
  - `x_rvalid_o` = (`owner_q` == x).
  - `x_rdata_o` = `ram_rdata_i` when `x_rvalid_o` is high, else 0.
  - On a write, `lsu_rvalid_o` pulses as an acknowledge and `lsu_rdata_o` carries `ram_rdata_i`, which is don't-care.
- **Requester rules.** A requester holds its request and address stable until it is granted. Dropping a request before grant is legal and has no side effect.
- **Reset.** Asynchronous. `owner_q`=IDLE and `streak_q`=0. All registered outputs reset to 0. Combinational outputs are 0 while the request inputs are 0.
  - An access granted in the cycle before reset assertion produces no `rvalid` after reset.

## Timing
- Grant is same cycle as request (0-cycle arbitration).
- Response arrives 1 cycle after grant.
- Back-to-back grants every cycle, so throughput is 1 access per cycle total.
- Simultaneous requests with `streak_q`=0: the LSU is granted.
- Worst-case IFU wait while requesting: `MAX_LSU_STREAK` cycles.
- A new grant in cycle N+1 coexists with the response of cycle N. No bubble is required.

## Configuration
- Macro: `JEDRO_1_ARB_RR_EN`.
- **Defined:** strict round-robin. Under contention, the winner is the requester not granted most recently (reset default: LSU first). The streak counter is not built and `MAX_LSU_STREAK` is ignored.
- **Undefined:** LSU priority with the streak limit, as described above.

## Test plan
- **IFU only.** Fetch 0x0, 0x4 and 0x8 back-to-back with RAM preloaded 0x00100093, 0x00200113, 0x00300193.
  - Grants occur in cycles 0/1/2.
  - `ifu_rvalid_o` is high in cycles 1/2/3 with those words.
  - `lsu_rvalid_o` stays 0.
- **LSU write then read.**
  - Write 0x55C to 0x100 with be=0xF, then read 0x100.
  - `ram_we_o`=0xF in the write cycle.
  - A write ack is seen, followed by `lsu_rdata_o`=0x55C one cycle after the read grant.
- **Byte enable.**
  - Write 0xAABBCCDD with be=0x3 over 0xFFFFFFFF; the read returns 0xFFFFCCDD.
- **Contention, default build.**
  - Both request continuously with `MAX_LSU_STREAK`=4.
  - Grant pattern is L,L,L,L,I repeating.
  - Each `rvalid` goes to the matching requester.
- **Contention, `JEDRO_1_ARB_RR_EN`.**
  - Same stimulus gives the pattern L,I,L,I,…
- **Reset mid-operation.**
  - Assert `rstn_i` low one cycle after an IFU grant.
  - `ifu_rvalid_o`=0 immediately, and there is no response after release.
  - The next simultaneous request grants the LSU.
